adc_frame_arbiter: RTL and testbench

- Read-side scheduler for the per-channel byte buffers in the ADC capture path.
- Round-robins over enabled channels and drains a fixed burst from each onto one 8-bit AXI-Stream, one framed packet per burst.
- Each packet is a 3-byte header followed by BURST_BYTES payload bytes, with tlast on the final byte.
- Sits between the channel width-converter FIFOs and the Ethernet/UDP stream packer, on the 125 MHz domain.

---
 rtl/adc_frame_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_adc_frame_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_arbiter.sv
// Read-side scheduler for the ADC channel byte buffers.
// Round-robins over the enabled channels and drains one fixed-size burst from
// each onto a single 8-bit AXI-Stream. Every burst goes out as one packet:
// a 3-byte header (sync, channel, sequence) followed by the payload, with
// tlast on the final payload byte.
module adc_frame_arbiter #(
    parameter int unsigned NUM_CH      = 6,
    parameter int unsigned BURST_BYTES = 1024,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic [NUM_CH-1:0]     ch_empty,
    input  logic [8*NUM_CH-1:0]   ch_dout,
    output logic [NUM_CH-1:0]     ch_rd_en,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [2:0]            cur_ch,
    output logic                  busy,
    output logic [7:0]            seq
);

    localparam int unsigned CH_W  = 3;
    localparam int unsigned CNT_W = $clog2(BURST_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_BYTES - 1);
    localparam logic [CH_W-1:0]  MAX_CH   = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_HDR0,
        S_HDR1,
        S_HDR2,
        S_PAYLOAD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [NUM_CH-1:0]  r_mask;
    logic [CH_W-1:0]    r_ptr;
    logic [CH_W-1:0]    r_cur_ch;
    logic [7:0]         r_seq;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;

    logic [CH_W-1:0]    w_sel_ch;
    logic [CH_W-1:0]    w_sel_hi;
    logic [CH_W-1:0]    w_sel_lo;
    logic               w_hi_found;
    logic [7:0]         w_pay_data;
    logic               w_pay_empty;
    logic               w_pay_hs;
    logic               w_last_beat;
    logic               w_can_start;

    assign w_can_start = enable && (|ch_mask);
    assign w_last_beat = (r_cnt == LAST_CNT);

    // Round-robin pick: lowest latched channel at or above the pointer, else lowest overall
    always_comb begin
        w_sel_hi   = '0;
        w_sel_lo   = '0;
        w_hi_found = 1'b0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (r_mask[j]) begin
                w_sel_lo = CH_W'(j);
                if (CH_W'(j) >= r_ptr) begin
                    w_sel_hi   = CH_W'(j);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_sel_ch = w_hi_found ? w_sel_hi : w_sel_lo;
    end

    // Head-of-buffer mux for the channel being drained
    always_comb begin
        w_pay_data  = '0;
        w_pay_empty = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_cur_ch == CH_W'(i)) begin
                w_pay_data  = ch_dout[8*i +: 8];
                w_pay_empty = ch_empty[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stream/pop outputs
    always_comb begin
        w_state_nxt   = r_state;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        ch_rd_en      = '0;
        w_pay_hs      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_start) begin
                    w_state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                w_state_nxt = S_HDR0;
            end
            S_HDR0: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = SYNC_BYTE;
                if (m_axis_tready) begin
                    w_state_nxt = S_HDR1;
                end
            end
            S_HDR1: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {5'b0, r_cur_ch};
                if (m_axis_tready) begin
                    w_state_nxt = S_HDR2;
                end
            end
            S_HDR2: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = r_seq;
                if (m_axis_tready) begin
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                m_axis_tvalid = !w_pay_empty;
                m_axis_tdata  = w_pay_data;
                m_axis_tlast  = !w_pay_empty && w_last_beat;
                w_pay_hs      = !w_pay_empty && m_axis_tready;
                if (w_pay_hs) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        ch_rd_en[i] = (r_cur_ch == CH_W'(i));
                    end
                    if (w_last_beat) begin
                        w_state_nxt = w_can_start ? S_SELECT : S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: mask latch, channel pick, byte counter, sequence and pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask   <= '0;
            r_ptr    <= '0;
            r_cur_ch <= '0;
            r_seq    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_state_nxt == S_SELECT) begin
                r_mask <= ch_mask;
            end
            if (r_state == S_SELECT) begin
                r_cur_ch <= w_sel_ch;
            end
            if (w_pay_hs) begin
                if (w_last_beat) begin
                    r_cnt <= '0;
                    r_seq <= r_seq + 8'd1;
                    r_ptr <= (r_cur_ch == MAX_CH) ? '0 : r_cur_ch + CH_W'(1);
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign cur_ch = r_cur_ch;
    assign busy   = r_busy;
    assign seq    = r_seq;

endmodule

// File: tb/tb_adc_frame_arbiter.sv
// Scoreboard bench for adc_frame_arbiter: a behavioural packet model pushes
// expected beats, a monitor pops and compares on every stream handshake.
module tb_adc_frame_arbiter;

    localparam int NUM_CH = 6;
    localparam int BURST  = 4;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int DEPTH  = 256;
    localparam int BUDGET = 3000;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic [NUM_CH-1:0]   ch_mask;
    logic [NUM_CH-1:0]   ch_empty;
    logic [8*NUM_CH-1:0] ch_dout;
    logic [NUM_CH-1:0]   ch_rd_en;
    logic [7:0]          tdata;
    logic                tvalid;
    logic                tready;
    logic                tlast;
    logic [2:0]          cur_ch;
    logic                busy;
    logic [7:0]          seq;

    always #4 clk = ~clk;

    adc_frame_arbiter #(
        .NUM_CH(NUM_CH),
        .BURST_BYTES(BURST),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .ch_mask(ch_mask),
        .ch_empty(ch_empty),
        .ch_dout(ch_dout),
        .ch_rd_en(ch_rd_en),
        .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast(tlast),
        .cur_ch(cur_ch),
        .busy(busy),
        .seq(seq)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       first;
        logic       pay;
        logic [2:0] ch;
    } exp_t;

    exp_t              sb[$];
    int                compared = 0;
    int                mismatched = 0;
    logic [7:0]        mem [NUM_CH][DEPTH];
    int                f_rd [NUM_CH];
    int                m_rd [NUM_CH];
    logic [NUM_CH-1:0] hold;
    int                m_ptr;
    int                m_seq;
    int                pos;
    int                hdr_cnt;
    bit                rand_rdy;
    logic [NUM_CH-1:0] rd_snap;

    function automatic void chk(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t mk(logic [7:0] d, logic l, logic f, logic p, int c);
        exp_t e;
        e.data = d; e.last = l; e.first = f; e.pay = p; e.ch = 3'(c);
        return e;
    endfunction

    // Channel buffers: first-word-fall-through view of each preloaded array
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_empty[c]       = (f_rd[c] >= DEPTH) || hold[c];
            ch_dout[8*c +: 8] = mem[c][f_rd[c] % DEPTH];
        end
    end

    // Buffer pops and downstream ready
    initial begin
        forever begin
            @(negedge clk);
            rd_snap = ch_rd_en;
            @(posedge clk);
            #1;
            for (int c = 0; c < NUM_CH; c++) if (rd_snap[c]) f_rd[c]++;
            tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare every handshake against the scoreboard
    initial begin
        exp_t e;
        logic [NUM_CH-1:0] exp_rd;
        bit stall, prev_rst;
        logic [7:0] s_data;
        logic s_last;
        stall = 0; prev_rst = 1; pos = 0; hdr_cnt = 0; s_data = 0; s_last = 0;
        forever begin
            @(negedge clk);
            exp_rd = '0;
            if (stall && !prev_rst) begin
                chk("stall_tvalid", int'(tvalid), 1);
                chk("stall_tdata", int'(tdata), int'(s_data));
                chk("stall_tlast", int'(tlast), int'(s_last));
            end
            if (tvalid && tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", int'(tdata), -1);
                end else begin
                    e = sb.pop_front();
                    chk("tdata", int'(tdata), int'(e.data));
                    chk("tlast", int'(tlast), int'(e.last));
                    if (e.pay) exp_rd[e.ch] = 1'b1;
                    if (e.first) hdr_cnt++;
                    pos = e.last ? 0 : pos + 1;
                end
            end
            chk("ch_rd_en", int'(ch_rd_en), int'(exp_rd));
            stall  = tvalid && !tready;
            s_data = tdata;
            s_last = tlast;
            if (rst) pos = 0;
            prev_rst = rst;
        end
    end

    // Reference model: next packets from the round-robin rule
    task automatic predict(input logic [NUM_CH-1:0] mask, input int k);
        for (int n = 0; n < k; n++) begin
            int ch;
            ch = -1;
            for (int i = 0; i < NUM_CH; i++) begin
                int c;
                c = (m_ptr + i) % NUM_CH;
                if (ch < 0 && mask[c]) ch = c;
            end
            sb.push_back(mk(SYNC, 1'b0, 1'b1, 1'b0, ch));
            sb.push_back(mk(8'(ch), 1'b0, 1'b0, 1'b0, ch));
            sb.push_back(mk(8'(m_seq), 1'b0, 1'b0, 1'b0, ch));
            for (int b = 0; b < BURST; b++) begin
                sb.push_back(mk(mem[ch][m_rd[ch]], b == BURST - 1, 1'b0, 1'b1, ch));
                m_rd[ch]++;
            end
            m_ptr = (ch + 1) % NUM_CH;
            m_seq = (m_seq + 1) % 256;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tvalid"}, int'(tvalid), 0);
        chk({tag, "_tdata"}, int'(tdata), 0);
        chk({tag, "_tlast"}, int'(tlast), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_seq"}, int'(seq), 0);
        chk({tag, "_cur_ch"}, int'(cur_ch), 0);
    endtask

    // Discard the partial packet and return its unsent payload to the model
    task automatic flush();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].pay) m_rd[int'(sb[i].ch)]--;
        end
        sb.delete();
        m_ptr = 0;
        m_seq = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        flush();
        rst = 1'b0;
    endtask

    // Raise enable from IDLE and measure cycles to the first tvalid
    task automatic start(input logic [NUM_CH-1:0] mask, input int k, output int base);
        int n;
        ch_mask = mask;
        base = hdr_cnt;
        predict(mask, k);
        enable = 1'b1;
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!tvalid && n < 20);
        chk("start_latency", n, 2);
    endtask

    task automatic wait_hdr(input int target);
        int t;
        bit done;
        done = 0;
        for (t = 0; t < BUDGET && !done; t++) begin
            @(posedge clk); #1;
            if (hdr_cnt >= target) done = 1;
        end
        chk("wait_hdr_done", int'(done), 1);
        enable = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < BUDGET) begin
            @(posedge clk); #1; t++;
        end
        chk("drain_left", sb.size(), 0);
        repeat (5) begin
            @(negedge clk);
            chk("idle_tvalid", int'(tvalid), 0);
            chk("idle_busy", int'(busy), 0);
            @(posedge clk); #1;
        end
        for (int c = 0; c < NUM_CH; c++) chk("pop_count", f_rd[c], m_rd[c]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        int t;
        bit done;
        rst = 1'b1; enable = 1'b0; ch_mask = '0; tready = 1'b1;
        hold = '0; rand_rdy = 0; m_ptr = 0; m_seq = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            f_rd[c] = 0;
            m_rd[c] = 0;
            for (int i = 0; i < DEPTH; i++) mem[c][i] = 8'($urandom);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset");
        chk("reset_rd_en", int'(ch_rd_en), 0);
        @(posedge clk); #1;

        // No start without both enable and a nonzero mask
        ch_mask = '0; enable = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("nomask_busy", int'(busy), 0);
        ch_mask = 6'b000011; enable = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("noenable_busy", int'(busy), 0);

        // Two-channel rotation, third packet started before enable drops
        start(6'b000011, 3, base);
        wait_hdr(base + 3);
        drain();

        // Sparse mask 2,5,2,5
        do_reset();
        start(6'b100100, 4, base);
        wait_hdr(base + 4);
        drain();

        // Random backpressure, random mask, then a single-channel run
        rand_rdy = 1;
        start(NUM_CH'($urandom_range(1, 63)), 6, base);
        wait_hdr(base + 6);
        drain();
        start(6'b000100, 3, base);
        wait_hdr(base + 3);
        drain();
        rand_rdy = 0;
        @(posedge clk); #1;

        // Buffer runs dry after two payload bytes
        start(6'b000010, 1, base);
        done = 0;
        for (t = 0; t < BUDGET && !done; t++) begin
            @(posedge clk); #1;
            if (hdr_cnt >= base + 1) enable = 1'b0;
            if (pos >= 5) done = 1;
        end
        chk("empty_reach", int'(done), 1);
        hold[1] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("empty_tvalid", int'(tvalid), 0);
            chk("empty_busy", int'(busy), 1);
            chk("empty_cur_ch", int'(cur_ch), 1);
            @(posedge clk); #1;
        end
        hold = '0;
        drain();

        // Enable dropped in HDR1: one full packet then idle
        do_reset();
        start(6'b000001, 1, base);
        wait_hdr(base + 1);
        drain();

        // Reset in the payload of the seq=7 packet
        do_reset();
        start(6'b000001, 8, base);
        done = 0;
        for (t = 0; t < BUDGET && !done; t++) begin
            @(posedge clk); #1;
            if (hdr_cnt >= base + 8 && pos >= 4) done = 1;
        end
        chk("rst_reach", int'(done), 1);
        chk("rst_seq_before", int'(seq), 7);
        rst = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        flush();
        @(negedge clk);
        check_zero("midrst");
        chk("midrst_rd_en", int'(ch_rd_en), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        start(6'b000001, 1, base);
        wait_hdr(base + 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
